// File: rtl/uart_pkg.sv
// Shared definitions for the arbitrated UART transmitter.
//   state_e       : frame sequencer states
//   PARITY_*      : encodings for the PARITY parameter of uart_tx_arbiter
//   DATA_BITS     : payload width of one frame
//   IDLE_LEVEL    : line level while nothing is being sent
//   parity_bit()  : parity bit for a payload byte under a given encoding
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_PAR   = 3'd3,
        ST_STOP  = 3'd4
    } state_e;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    localparam int   DATA_BITS  = 8;
    localparam logic IDLE_LEVEL = 1'b1;

    function automatic logic parity_bit(input logic [DATA_BITS-1:0] b, input int mode);
        return (mode == PARITY_ODD) ? ~(^b) : (^b);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector.
//   req   : request vector
//   ptr   : index that currently has highest priority
//   gnt   : one-hot selection (all zero when nothing requests)
//   idx   : binary index of the selected requester
//   valid : a requester was selected
module rr_arbiter #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0] req,
    input  logic [2:0]      ptr,
    output logic [NREQ-1:0] gnt,
    output logic [2:0]      idx,
    output logic            valid
);

    // Walk priority distance k outward from ptr; the first hit wins.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!valid && req[i] && (i == ((int'(ptr) + k) % NREQ))) begin
                    gnt[i] = 1'b1;
                    idx    = 3'(i);
                    valid  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmit line between NREQ byte requesters.
//   clk, rst_n : clock, asynchronous active-low reset
//   req, data  : per-requester request and byte (byte i at data[8i+7:8i])
//   gnt        : one-hot pulse in the cycle requester i's byte is captured
//   baud_tick  : bit-period tick from the external generator
//   baud_en    : runs the tick generator while a frame is on the line
//   txd        : serial output, idles high
//   busy       : grant cycle through end of stop bit
//   owner      : index of the requester whose frame is (or was last) sent
//
// state    | meaning
// ---------+---------------------------------------------
// ST_IDLE  | line high, arbitrate and capture a byte
// ST_START | start bit (low)
// ST_DATA  | payload bits, LSB first
// ST_PAR   | parity bit (only when PARITY != 0)
// ST_STOP  | stop bit (high)
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int PARITY = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [8*NREQ-1:0] data,
    output logic [NREQ-1:0]   gnt,
    input  logic              baud_tick,
    output logic              baud_en,
    output logic              txd,
    output logic              busy,
    output logic [2:0]        owner
);

    state_e                 state;
    logic [2:0]             bit_idx;
    logic [2:0]             ptr;
    logic [DATA_BITS-1:0]   shreg;
    logic [DATA_BITS-1:0]   sel_byte;
    logic [NREQ-1:0]        arb_gnt;
    logic [2:0]             arb_idx;
    logic                   arb_valid;
    logic [2:0]             ptr_next;
    logic                   grant_now;

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .req   (req),
        .ptr   (ptr),
        .gnt   (arb_gnt),
        .idx   (arb_idx),
        .valid (arb_valid)
    );

    // gnt and busy are decoded from req, so they are also gated by rst_n
    // to stay low for the whole time reset is held.
    assign grant_now = rst_n && (state == ST_IDLE) && arb_valid;
    assign gnt       = grant_now ? arb_gnt : '0;
    assign baud_en   = (state != ST_IDLE);
    assign busy      = baud_en || grant_now;
    assign ptr_next  = (arb_idx == 3'(NREQ - 1)) ? 3'd0 : arb_idx + 3'd1;

    always_comb begin
        sel_byte = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (arb_gnt[i]) sel_byte = data[8*i +: 8];
        end
    end

    always_comb begin
        txd = IDLE_LEVEL;
        case (state)
            ST_START: txd = 1'b0;
            ST_DATA:  txd = shreg[bit_idx];
            ST_PAR:   txd = parity_bit(shreg, PARITY);
            ST_STOP:  txd = 1'b1;
            default:  txd = IDLE_LEVEL;
        endcase
    end

    // baud_tick is only acted on outside ST_IDLE, so stray ticks while idle
    // fall through without effect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            bit_idx <= '0;
            shreg   <= '0;
            owner   <= '0;
            ptr     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (arb_valid) begin
                        shreg   <= sel_byte;
                        owner   <= arb_idx;
                        ptr     <= ptr_next;
                        bit_idx <= '0;
                        state   <= ST_START;
                    end
                end
                ST_START: begin
                    if (baud_tick) begin
                        bit_idx <= '0;
                        state   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (baud_tick) begin
                        if (bit_idx == 3'(DATA_BITS - 1))
                            state <= (PARITY != PARITY_NONE) ? ST_PAR : ST_STOP;
                        else
                            bit_idx <= bit_idx + 3'd1;
                    end
                end
                ST_PAR: begin
                    if (baud_tick) state <= ST_STOP;
                end
                ST_STOP: begin
                    if (baud_tick) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a PARITY=0 instance for arbitration,
// framing and reset, plus even/odd parity instances fed in lockstep.
module tb_uart_tx_arbiter;

    typedef struct {
        logic [10:0] bits;
        int          len;
    } frame_t;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req, req_p;
    logic [31:0] data, data_p;
    logic [3:0]  gnt, gnt_e, gnt_o;
    logic        baud_tick, tick_p;
    logic        baud_en, en_e, en_o;
    logic        txd, txd_e, txd_o;
    logic        busy, busy_e, busy_o;
    logic [2:0]  owner, owner_e, owner_o;
    logic        spur;

    int n_checks = 0;
    int n_fail   = 0;

    int     gq[$];
    frame_t fq0[$], fq1[$], fq2[$];
    int     gap_log[$];

    uart_tx_arbiter #(.NREQ(4), .PARITY(0)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .data(data), .gnt(gnt),
        .baud_tick(baud_tick), .baud_en(baud_en), .txd(txd), .busy(busy), .owner(owner)
    );

    uart_tx_arbiter #(.NREQ(4), .PARITY(1)) dut_even (
        .clk(clk), .rst_n(rst_n), .req(req_p), .data(data_p), .gnt(gnt_e),
        .baud_tick(tick_p), .baud_en(en_e), .txd(txd_e), .busy(busy_e), .owner(owner_e)
    );

    uart_tx_arbiter #(.NREQ(4), .PARITY(2)) dut_odd (
        .clk(clk), .rst_n(rst_n), .req(req_p), .data(data_p), .gnt(gnt_o),
        .baud_tick(tick_p), .baud_en(en_o), .txd(txd_o), .busy(busy_o), .owner(owner_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic frame_t mk_frame(input logic [7:0] b, input int par);
        frame_t f;
        f.bits    = '0;
        f.bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) f.bits[1+i] = b[i];
        if (par == 0) begin
            f.bits[9] = 1'b1;
            f.len     = 10;
        end else begin
            f.bits[9]  = (par == 2) ? ~(^b) : (^b);
            f.bits[10] = 1'b1;
            f.len      = 11;
        end
        return f;
    endfunction

    // Tick generators: 4 clk per bit, restarting whenever baud_en is low.
    initial begin
        int c0, c1;
        c0 = 0; c1 = 0;
        baud_tick = 1'b0;
        tick_p    = 1'b0;
        forever begin
            @(posedge clk); #2;
            if (!baud_en) begin
                c0 = 0;
                baud_tick = spur;
            end else begin
                c0++;
                baud_tick = (c0 == 4);
                if (c0 == 4) c0 = 0;
            end
            if (!en_e) begin
                c1 = 0;
                tick_p = 1'b0;
            end else begin
                c1++;
                tick_p = (c1 == 4);
                if (c1 == 4) c1 = 0;
            end
        end
    end

    task automatic check_frame(input int c, input logic [10:0] got, input int n, input int ec);
        frame_t e;
        bit     have;
        have = 1'b0;
        e.bits = '0;
        e.len  = 0;
        case (c)
            0: if (fq0.size() > 0) begin e = fq0.pop_front(); have = 1'b1; end
            1: if (fq1.size() > 0) begin e = fq1.pop_front(); have = 1'b1; end
            default: if (fq2.size() > 0) begin e = fq2.pop_front(); have = 1'b1; end
        endcase
        check($sformatf("frame%0d_expected", c), 32'(have), 1);
        if (have) begin
            check($sformatf("frame%0d_ticks", c), n, e.len);
            check($sformatf("frame%0d_bits", c), 32'(got), 32'(e.bits));
            check($sformatf("frame%0d_en_cycles", c), ec, 4 * e.len);
        end
    endtask

    // Output monitor / scoreboard consumer.
    initial begin
        logic [2:0]  ch_en, ch_tk, ch_tx;
        logic [10:0] got [3];
        int          nt [3];
        int          ecyc [3];
        bit          inf [3];
        bit          own_pend, had_frame;
        int          own_exp, gap_cnt, e;
        own_pend = 0; had_frame = 0; own_exp = 0; gap_cnt = 0;
        for (int c = 0; c < 3; c++) begin
            got[c] = '0; nt[c] = 0; ecyc[c] = 0; inf[c] = 0;
        end
        forever begin
            @(negedge clk);
            ch_en = {en_o, en_e, baud_en};
            ch_tk = {tick_p, tick_p, baud_tick};
            ch_tx = {txd_o, txd_e, txd};
            if (!rst_n) begin
                own_pend  = 0;
                had_frame = 0;
                for (int c = 0; c < 3; c++) begin
                    got[c] = '0; nt[c] = 0; ecyc[c] = 0; inf[c] = 0;
                end
            end else begin
                if (own_pend) begin
                    check("owner", 32'(owner), own_exp);
                    own_pend = 0;
                end
                if (gnt !== 4'b0000) begin
                    check("gnt_only_in_idle", 32'(baud_en), 0);
                    check("busy_at_gnt", 32'(busy), 1);
                    if (gq.size() == 0) begin
                        check("gnt_unexpected", 32'(gnt), 0);
                    end else begin
                        e = gq.pop_front();
                        check("gnt", 32'(gnt), 32'(1) << e);
                        own_exp  = e;
                        own_pend = 1;
                    end
                end
                for (int c = 0; c < 3; c++) begin
                    if (ch_en[c]) begin
                        if (c == 0 && !inf[0] && had_frame) gap_log.push_back(gap_cnt);
                        inf[c] = 1;
                        ecyc[c]++;
                        if (ch_tk[c]) begin
                            if (nt[c] < 11) got[c][nt[c]] = ch_tx[c];
                            nt[c]++;
                        end
                    end else if (inf[c]) begin
                        check_frame(c, got[c], nt[c], ecyc[c]);
                        inf[c] = 0; nt[c] = 0; ecyc[c] = 0; got[c] = '0;
                        if (c == 0) begin
                            had_frame = 1;
                            gap_cnt   = 1;
                        end
                    end else if (c == 0 && had_frame) begin
                        gap_cnt++;
                    end
                end
            end
        end
    end

    task automatic wait_gnt(input bit par, input bit drop, output logic [3:0] g);
        g = '0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            g = par ? gnt_e : gnt;
            if (g != 4'b0000) break;
        end
        check(par ? "gnt_wait_par" : "gnt_wait", 32'(g != 4'b0000), 1);
        @(posedge clk); #1;
        if (drop) begin
            if (par) req_p = req_p & ~g;
            else     req   = req & ~g;
        end
    endtask

    task automatic wait_idle(input bit par);
        logic en;
        en = 1'b1;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            en = par ? en_e : baud_en;
            if (!en) break;
        end
        check(par ? "idle_wait_par" : "idle_wait", 32'(en), 0);
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_txd"}, 32'(txd), 1);
        check({tag, "_baud_en"}, 32'(baud_en), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_gnt"}, 32'(gnt), 0);
        check({tag, "_owner"}, 32'(owner), 0);
    endtask

    initial begin
        logic [3:0] g;
        int         ticks;
        rst_n  = 1'b0;
        req    = '0;
        req_p  = '0;
        data   = '0;
        data_p = '0;
        spur   = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Stray ticks while idle
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            spur = (i % 2 == 0);
            @(negedge clk);
            check("spur_txd", 32'(txd), 1);
            check("spur_gnt", 32'(gnt), 0);
            check("spur_baud_en", 32'(baud_en), 0);
        end
        @(posedge clk); #1;
        spur = 1'b0;
        @(negedge clk);
        check("spur_busy", 32'(busy), 0);
        check("spur_owner", 32'(owner), 0);

        // Four requesters, each dropping after its grant
        data = {8'hC4, 8'h3B, 8'h92, 8'h6E};
        gap_log.delete();
        for (int i = 0; i < 4; i++) begin
            gq.push_back(i);
            fq0.push_back(mk_frame(data[8*i +: 8], 0));
        end
        @(posedge clk); #1;
        req = 4'b1111;
        for (int i = 0; i < 4; i++) wait_gnt(0, 1, g);
        wait_idle(0);
        check("gap_count_4req", gap_log.size(), 3);
        foreach (gap_log[i]) check("gap_len_4req", gap_log[i], 1);

        // Single request 0x55
        data[7:0] = 8'h55;
        gq.push_back(0);
        fq0.push_back(mk_frame(8'h55, 0));
        @(posedge clk); #1;
        req = 4'b0001;
        wait_gnt(0, 1, g);
        wait_idle(0);
        check("single_txd_idle", 32'(txd), 1);

        // Return priority to requester 0
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("reset_pulse");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Fairness with all requests held across eight frames
        gap_log.delete();
        for (int f = 0; f < 8; f++) begin
            gq.push_back(f % 4);
            fq0.push_back(mk_frame(data[8*(f%4) +: 8], 0));
        end
        @(posedge clk); #1;
        req = 4'b1111;
        for (int f = 0; f < 8; f++) wait_gnt(0, (f == 7), g);
        req = 4'b0000;
        wait_idle(0);
        check("gap_count_fair", gap_log.size(), 7);
        foreach (gap_log[i]) check("gap_len_fair", gap_log[i], 1);

        // Reset in the middle of data bit 4 (frame abandoned, not scored)
        data[15:8] = 8'hA5;
        gq.push_back(1);
        @(posedge clk); #1;
        req = 4'b0010;
        wait_gnt(0, 1, g);
        ticks = 0;
        for (int k = 0; k < 200 && ticks < 5; k++) begin
            @(negedge clk);
            if (baud_en && baud_tick) ticks++;
        end
        check("midframe_ticks", ticks, 5);
        @(posedge clk); #1;
        check("midframe_bit4", 32'(txd), 0);
        check("midframe_owner", 32'(owner), 1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midframe_reset");
        data[23:16] = 8'h3C;
        req = 4'b0100;
        repeat (2) @(negedge clk);
        check("reset_hold_gnt", 32'(gnt), 0);
        gq.push_back(2);
        fq0.push_back(mk_frame(8'h3C, 0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        wait_gnt(0, 1, g);
        wait_idle(0);

        // Even and odd parity on 0x07
        data_p[7:0] = 8'h07;
        fq1.push_back(mk_frame(8'h07, 1));
        fq2.push_back(mk_frame(8'h07, 2));
        @(posedge clk); #1;
        req_p = 4'b0001;
        wait_gnt(1, 1, g);
        check("gnt_even", 32'(g), 32'h1);
        wait_idle(1);
        @(negedge clk);

        check("gq_drained", gq.size(), 0);
        check("fq0_drained", fq0.size(), 0);
        check("fq1_drained", fq1.size(), 0);
        check("fq2_drained", fq2.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
